// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types, codes and limits for the stopwatch control slice.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_STOP     = 2'd0,
      ST_RUN      = 2'd1,
      ST_EDIT_MIN = 2'd2,
      ST_EDIT_SEC = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      FIELD_NONE = 2'd0,
      FIELD_MIN  = 2'd1,
      FIELD_SEC  = 2'd2
   } field_e;

   localparam int MIN_MAX_DEF   = 59;
   localparam int SEC_MAX_DEF   = 59;
   localparam int DECI_MAX_DEF  = 9;
   localparam int BLINK_MAX_DEF = 24_999_999;

   // Field increment that wraps back to zero once the field limit is reached.
   function automatic logic [7:0] wrap_inc(input logic [7:0] val, input logic [7:0] max);
      return (val >= max) ? 8'd0 : val + 8'd1;
   endfunction

   // Out-of-range captured values are treated as zero rather than saturated.
   function automatic logic [7:0] capture_field(input logic [7:0] val, input logic [7:0] max);
      return (val > max) ? 8'd0 : val;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Key pulses and counter-facing signals between keypad/counter and the controller.
interface stopwatch_ctrl_if;
   import stopwatch_pkg::*;

   logic        key_start;
   logic        key_clear;
   logic        key_set;
   logic        key_inc;
   logic [23:0] time_now;
   logic        run;
   logic [23:0] update;
   logic        update_trigger;
   logic [1:0]  edit_field;
   logic        blink;

   // Keypad / counter side.
   modport master (
      output key_start, key_clear, key_set, key_inc, time_now,
      input  run, update, update_trigger, edit_field, blink
   );

   // Controller side.
   modport slave (
      input  key_start, key_clear, key_set, key_inc, time_now,
      output run, update, update_trigger, edit_field, blink
   );

endinterface

// File: rtl/stopwatch_ctrl_blink_gen.sv
// Blink phase generator for the field being edited.
module blink_gen #(
   parameter int BLINK_MAX = 24_999_999
) (
   input  logic sclk,
   input  logic nrst,
   input  logic en,
   input  logic restart,
   output logic blink
);

   localparam int CW = (BLINK_MAX > 0) ? $clog2(BLINK_MAX + 1) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          blink_q, blink_d;

   // Restart starts a fresh visible phase; disabled forces everything low.
   always_comb begin
      cnt_d   = cnt_q;
      blink_d = blink_q;
      if (!en) begin
         cnt_d   = '0;
         blink_d = 1'b0;
      end else if (restart) begin
         cnt_d   = '0;
         blink_d = 1'b1;
      end else if (cnt_q == CW'(BLINK_MAX)) begin
         cnt_d   = '0;
         blink_d = ~blink_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Phase counter and blink register.
   always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
         cnt_q   <= '0;
         blink_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         blink_q <= blink_d;
      end
   end

   assign blink = blink_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop and time-edit controller.
//
//   state       | meaning
//   ST_STOP     | counter halted; clear loads zero, set enters edit
//   ST_RUN      | counter running; only start (stop) is honoured
//   ST_EDIT_MIN | minute shadow being edited
//   ST_EDIT_SEC | second shadow being edited; set commits to counter
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int MIN_MAX   = MIN_MAX_DEF,
   parameter int SEC_MAX   = SEC_MAX_DEF,
   parameter int BLINK_MAX = BLINK_MAX_DEF
) (
   input  logic             sclk,
   input  logic             nrst,
   stopwatch_ctrl_if.slave  bus
);

   localparam logic [7:0] MIN_LIM = 8'(MIN_MAX);
   localparam logic [7:0] SEC_LIM = 8'(SEC_MAX);

   state_e      state_q, state_d;
   logic [7:0]  min_q, min_d;
   logic [7:0]  sec_q, sec_d;
   logic        run_q, run_d;
   logic [23:0] update_q, update_d;
   logic        trig_q, trig_d;
   logic [1:0]  field_q, field_d;
   logic        blink_en, blink_restart;

   // Deci-seconds are never edited; a commit always loads zero there.
   logic        unused_deci;
   assign unused_deci = ^bus.time_now[7:0];

   // Next state, shadow and output values with key priority clear > set > start > inc.
   always_comb begin
      state_d       = state_q;
      min_d         = min_q;
      sec_d         = sec_q;
      update_d      = update_q;
      trig_d        = 1'b0;
      blink_restart = 1'b0;
      unique case (state_q)
         ST_STOP: begin
            if (bus.key_clear) begin
               update_d = 24'd0;
               trig_d   = 1'b1;
            end else if (bus.key_set) begin
               state_d       = ST_EDIT_MIN;
               min_d         = capture_field(bus.time_now[23:16], MIN_LIM);
               sec_d         = capture_field(bus.time_now[15:8], SEC_LIM);
               blink_restart = 1'b1;
            end else if (bus.key_start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.key_start) state_d = ST_STOP;
         end
         ST_EDIT_MIN: begin
            if (bus.key_clear) begin
               state_d = ST_STOP;
               min_d   = 8'd0;
               sec_d   = 8'd0;
            end else if (bus.key_set) begin
               state_d       = ST_EDIT_SEC;
               blink_restart = 1'b1;
            end else if (bus.key_inc) begin
               min_d         = wrap_inc(min_q, MIN_LIM);
               blink_restart = 1'b1;
            end
         end
         ST_EDIT_SEC: begin
            if (bus.key_clear) begin
               state_d = ST_STOP;
               min_d   = 8'd0;
               sec_d   = 8'd0;
            end else if (bus.key_set) begin
               state_d  = ST_STOP;
               update_d = {min_q, sec_q, 8'd0};
               trig_d   = 1'b1;
               min_d    = 8'd0;
               sec_d    = 8'd0;
            end else if (bus.key_inc) begin
               sec_d         = wrap_inc(sec_q, SEC_LIM);
               blink_restart = 1'b1;
            end
         end
         default: state_d = ST_STOP;
      endcase

      run_d = (state_d == ST_RUN);
      unique case (state_d)
         ST_EDIT_MIN: field_d = FIELD_MIN;
         ST_EDIT_SEC: field_d = FIELD_SEC;
         default:     field_d = FIELD_NONE;
      endcase
      blink_en = (state_d == ST_EDIT_MIN) || (state_d == ST_EDIT_SEC);
   end

   // State, shadow and registered outputs.
   always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= ST_STOP;
         min_q    <= 8'd0;
         sec_q    <= 8'd0;
         run_q    <= 1'b0;
         update_q <= 24'd0;
         trig_q   <= 1'b0;
         field_q  <= FIELD_NONE;
      end else begin
         state_q  <= state_d;
         min_q    <= min_d;
         sec_q    <= sec_d;
         run_q    <= run_d;
         update_q <= update_d;
         trig_q   <= trig_d;
         field_q  <= field_d;
      end
   end

   blink_gen #(.BLINK_MAX(BLINK_MAX)) u_blink (
      .sclk    (sclk),
      .nrst    (nrst),
      .en      (blink_en),
      .restart (blink_restart),
      .blink   (bus.blink)
   );

   assign bus.run            = run_q;
   assign bus.update         = update_q;
   assign bus.update_trigger = trig_q;
   assign bus.edit_field     = field_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

   localparam int MIN_MAX   = 59;
   localparam int SEC_MAX   = 59;
   localparam int BLINK_MAX = 3;

   logic sclk = 1'b0;
   logic nrst = 1'b0;
   always #5 sclk = ~sclk;

   stopwatch_ctrl_if bus();

   stopwatch_ctrl #(
      .MIN_MAX   (MIN_MAX),
      .SEC_MAX   (SEC_MAX),
      .BLINK_MAX (BLINK_MAX)
   ) dut (
      .sclk (sclk),
      .nrst (nrst),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   // reference model: a running flag, which field is being edited, shadow
   // numbers and the number of cycles since the blink phase last restarted
   bit          m_running;
   int          m_edit;
   int          m_min, m_sec;
   logic [23:0] m_upd;
   bit          m_trig;
   int          m_age;

   task automatic check_one(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      bit exp_blink;
      exp_blink = (m_edit != 0) && (((m_age / (BLINK_MAX + 1)) % 2) == 0);
      check_one({tag, ".run"},   24'(bus.run),            24'(m_running));
      check_one({tag, ".upd"},   bus.update,              m_upd);
      check_one({tag, ".trig"},  24'(bus.update_trigger), 24'(m_trig));
      check_one({tag, ".field"}, 24'(bus.edit_field),     24'(m_edit));
      check_one({tag, ".blink"}, 24'(bus.blink),          24'(exp_blink));
   endtask

   task automatic model_reset();
      m_running = 0; m_edit = 0; m_min = 0; m_sec = 0;
      m_upd = 24'd0; m_trig = 0; m_age = 0;
   endtask

   task automatic model_step(input bit s, input bit c, input bit se, input bit i);
      int tmin, tsec;
      tmin = int'(bus.time_now[23:16]);
      tsec = int'(bus.time_now[15:8]);
      m_trig = 0;
      if (m_running) begin
         if (s) m_running = 0;
      end else if (m_edit == 0) begin
         if (c) begin
            m_upd = 24'd0; m_trig = 1;
         end else if (se) begin
            m_edit = 1;
            m_min = (tmin > MIN_MAX) ? 0 : tmin;
            m_sec = (tsec > SEC_MAX) ? 0 : tsec;
            m_age = 0;
         end else if (s) begin
            m_running = 1;
         end
      end else begin
         if (c) begin
            m_edit = 0; m_min = 0; m_sec = 0;
         end else if (se) begin
            if (m_edit == 1) begin
               m_edit = 2; m_age = 0;
            end else begin
               m_upd = {8'(m_min), 8'(m_sec), 8'd0};
               m_trig = 1; m_edit = 0;
            end
         end else if (i) begin
            if (m_edit == 1) m_min = (m_min + 1) % (MIN_MAX + 1);
            else             m_sec = (m_sec + 1) % (SEC_MAX + 1);
            m_age = 0;
         end else begin
            m_age++;
         end
      end
   endtask

   task automatic tick(input bit s, input bit c, input bit se, input bit i, input string tag);
      @(negedge sclk);
      bus.key_start = s; bus.key_clear = c; bus.key_set = se; bus.key_inc = i;
      @(posedge sclk);
      model_step(s, c, se, i);
      #1;
      bus.key_start = 0; bus.key_clear = 0; bus.key_set = 0; bus.key_inc = 0;
      check_all(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int k = 0; k < n; k++) tick(0, 0, 0, 0, tag);
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge sclk);
      nrst = 0;
      bus.key_start = 0; bus.key_clear = 0; bus.key_set = 0; bus.key_inc = 0;
      #1;
      model_reset();
      check_all(tag);
      @(posedge sclk);
      #2 nrst = 1;
   endtask

   initial begin
      bus.key_start = 0; bus.key_clear = 0; bus.key_set = 0; bus.key_inc = 0;
      bus.time_now  = 24'd0;
      model_reset();

      pulse_reset("reset");

      // run/stop timing
      idle(9, "pre_start");
      tick(1, 0, 0, 0, "start10");
      check_one("run_rises", 24'(bus.run), 24'd1);
      idle(9, "running");
      tick(1, 0, 0, 0, "start20");
      check_one("run_falls", 24'(bus.run), 24'd0);
      check_one("stop_no_trig", 24'(bus.update_trigger), 24'd0);

      // clear in STOP
      bus.time_now = {8'd12, 8'd34, 8'd5};
      tick(0, 1, 0, 0, "clear");
      check_one("clear_trig", 24'(bus.update_trigger), 24'd1);
      check_one("clear_val", bus.update, 24'h000000);
      idle(1, "clear_after");

      // edit sequence with minute wrap
      bus.time_now = {8'd58, 8'd30, 8'd4};
      tick(0, 0, 1, 0, "set_min");
      tick(0, 0, 0, 1, "inc_min1");
      tick(0, 0, 0, 1, "inc_min2");
      tick(0, 0, 1, 0, "set_sec");
      tick(0, 0, 0, 1, "inc_sec");
      tick(0, 0, 1, 0, "commit");
      check_one("commit_val", bus.update, {8'd0, 8'd31, 8'd0});
      check_one("commit_trig", 24'(bus.update_trigger), 24'd1);
      idle(2, "commit_after");
      check_one("commit_hold", bus.update, {8'd0, 8'd31, 8'd0});

      // coincident set+start, then abort from seconds
      tick(1, 0, 1, 0, "set_start");
      check_one("prio_field", 24'(bus.edit_field), 24'd1);
      tick(0, 0, 1, 0, "to_sec");
      tick(0, 1, 0, 0, "abort");
      idle(2, "abort_after");

      // RUN ignores everything but start; out-of-range minute capture
      tick(1, 0, 0, 0, "run_again");
      tick(0, 0, 1, 0, "run_set");
      tick(0, 1, 0, 0, "run_clear");
      tick(0, 0, 0, 1, "run_inc");
      tick(1, 0, 0, 0, "run_stop");
      bus.time_now = {8'd70, 8'd10, 8'd2};
      tick(0, 0, 1, 0, "cap70");
      tick(0, 0, 1, 0, "cap70_sec");
      tick(0, 0, 1, 0, "cap70_commit");
      check_one("cap70_val", bus.update, {8'd0, 8'd10, 8'd0});

      // blink phases, restart on inc, reset mid-edit
      tick(0, 0, 1, 0, "blink_enter");
      idle(9, "blink_run");
      tick(0, 0, 0, 1, "blink_inc");
      check_one("blink_restart", 24'(bus.blink), 24'd1);
      idle(5, "blink_run2");
      tick(0, 0, 1, 0, "blink_sec");
      idle(2, "blink_sec_run");
      pulse_reset("mid_edit_reset");
      tick(0, 0, 0, 0, "post_reset");
      tick(1, 0, 0, 0, "post_reset_start");
      tick(1, 0, 0, 0, "post_reset_stop");

      // randomized keys and counter values against the model
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 7) == 0)
            bus.time_now = {8'($urandom_range(0, 80)), 8'($urandom_range(0, 80)),
                            8'($urandom_range(0, 9))};
         tick($urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, "rand");
         if ($urandom_range(0, 199) == 0) pulse_reset("rand_reset");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
